// File: rtl/dmem_responder_if.sv
// Load/store request/response bundle between the core memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_store_type;
  logic [2:0]  req_load_type;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_store_type, req_load_type,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_store_type, req_load_type,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder over a word-organised SRAM with
// byte/half/word access. Optional wait states enabled by DMEM_WAIT_STATE_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef DMEM_WAIT_STATE_EN
  localparam logic [1:0] S_WAIT   = 2'd1;
`endif
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_store_type;
  logic [2:0]  r_load_type;

`ifdef DMEM_WAIT_STATE_EN
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_cnt_next;
`else
  // WAIT_CYCLES has no effect without the wait-state feature.
  if (WAIT_CYCLES > 15) begin : g_wait_cycles_ignored
  end
`endif

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_is_half;
  logic          w_is_word;
  logic          w_illegal;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_shifted;
  logic [31:0]   w_load_data;
  logic          w_mem_we;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wlane;

  assign w_accept = bus.req_valid && r_req_ready && (r_state == S_IDLE);
  assign w_idx    = r_addr[AW+1:2];
  assign w_word   = r_mem[w_idx];

  // Access decode, error detection, load extraction and store lane steering.
  always_comb begin
    w_is_half   = 1'b0;
    w_is_word   = 1'b0;
    w_illegal   = 1'b0;
    w_load_data = 32'd0;
    w_wmask     = 4'b0000;
    w_wlane     = 32'd0;

    if (r_write) begin
      case (r_store_type)
        2'b00:   begin w_wmask = 4'(4'b0001 << r_addr[1:0]); w_wlane = {4{r_wdata[7:0]}}; end
        2'b01:   begin
          w_is_half = 1'b1;
          w_wmask   = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wlane   = {2{r_wdata[15:0]}};
        end
        2'b10:   begin w_is_word = 1'b1; w_wmask = 4'b1111; w_wlane = r_wdata; end
        default: w_illegal = 1'b1;
      endcase
    end else begin
      case (r_load_type)
        3'b000, 3'b100: ;
        3'b001, 3'b101: w_is_half = 1'b1;
        3'b010:         w_is_word = 1'b1;
        default:        w_illegal = 1'b1;
      endcase
    end

    w_err = w_illegal
         || (w_is_half && r_addr[0])
         || (w_is_word && (r_addr[1:0] != 2'b00))
         || (r_addr[31:2] >= 30'(DEPTH_WORDS));

    w_shifted = w_word >> {r_addr[1:0], 3'b000};
    case (r_load_type)
      3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_data = w_shifted;
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = 32'd0;
    endcase

    w_mem_we = (r_state == S_ACCESS) && r_write && !w_err;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
`ifdef DMEM_WAIT_STATE_EN
    w_wait_cnt_next = r_wait_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef DMEM_WAIT_STATE_EN
          if (WAIT_CYCLES > 0) begin
            w_next_state    = S_WAIT;
            w_wait_cnt_next = 4'(WAIT_CYCLES - 1);
          end else begin
            w_next_state = S_ACCESS;
          end
`else
          w_next_state = S_ACCESS;
`endif
        end
      end
`ifdef DMEM_WAIT_STATE_EN
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) w_next_state = S_ACCESS;
        else                    w_wait_cnt_next = 4'(r_wait_cnt - 4'd1);
      end
`endif
      S_ACCESS: w_next_state = S_RESP;
      S_RESP:   if (bus.rsp_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      r_wait_cnt  <= 4'd0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == S_IDLE);
      r_rsp_valid <= (w_next_state == S_RESP);
`ifdef DMEM_WAIT_STATE_EN
      r_wait_cnt  <= w_wait_cnt_next;
`endif
    end
  end

  // Request capture and response result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_store_type <= 2'd0;
      r_load_type  <= 3'd0;
      r_rsp_rdata  <= 32'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write      <= bus.req_write;
        r_addr       <= bus.req_addr;
        r_wdata      <= bus.req_wdata;
        r_store_type <= bus.req_store_type;
        r_load_type  <= bus.req_load_type;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_rdata <= (w_err || r_write) ? 32'd0 : w_load_data;
        r_rsp_err   <= w_err;
      end
    end
  end

  // SRAM byte-lane write; a reset on the ACCESS edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst && w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder: table of load/store transactions
// plus hand-written backpressure and mid-transaction reset sequences.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WC    = 2;
`ifdef DMEM_WAIT_STATE_EN
  localparam int W_EFF = WC;
`else
  localparam int W_EFF = 0;
`endif
  localparam int EXP_LAT = 2 + W_EFF;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_responder_if bus_if ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t st_v(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d,
                                input logic err);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.wdata = d; v.st = st; v.lt = 3'b111;
    v.exp_rdata = 32'd0; v.exp_err = err;
    return v;
  endfunction

  function automatic vec_t ld_v(input logic [2:0] lt, input logic [31:0] a,
                                input logic [31:0] exp, input logic err);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.wdata = 32'hA5A5_A5A5; v.st = 2'b11; v.lt = lt;
    v.exp_rdata = exp; v.exp_err = err;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] st, input logic [2:0] lt,
                        output logic [31:0] rd, output logic er, output int lat,
                        output bit ok);
    int n;
    ok = 1'b0; rd = 32'd0; er = 1'b0; lat = 0;
    @(negedge clk);
    bus_if.req_valid      = 1'b1;
    bus_if.req_write      = wr;
    bus_if.req_addr       = a;
    bus_if.req_wdata      = wd;
    bus_if.req_store_type = st;
    bus_if.req_load_type  = lt;
    n = 0;
    while (!bus_if.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus_if.req_ready) begin bus_if.req_valid = 1'b0; return; end
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    // lat = edges from the accepting edge to the edge that sees rsp_valid
    lat = 1;
    @(negedge clk);
    while (!bus_if.rsp_valid && lat < 40) begin lat++; @(negedge clk); end
    if (!bus_if.rsp_valid) return;
    rd = bus_if.rsp_rdata;
    er = bus_if.rsp_err;
    ok = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          ok;
    int          n;

    vecs[0]  = st_v(2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
    vecs[1]  = ld_v(3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
    vecs[2]  = ld_v(3'b000, 32'h13, 32'hFFFF_FFDE, 1'b0);
    vecs[3]  = ld_v(3'b100, 32'h13, 32'h0000_00DE, 1'b0);
    vecs[4]  = ld_v(3'b001, 32'h12, 32'hFFFF_DEAD, 1'b0);
    vecs[5]  = ld_v(3'b101, 32'h12, 32'h0000_DEAD, 1'b0);
    vecs[6]  = st_v(2'b00, 32'h11, 32'h0000_0055, 1'b0);
    vecs[7]  = ld_v(3'b010, 32'h10, 32'hDEAD_55EF, 1'b0);
    vecs[8]  = ld_v(3'b010, 32'h12, 32'd0, 1'b1);
    vecs[9]  = st_v(2'b01, 32'h11, 32'h0000_1234, 1'b1);
    vecs[10] = ld_v(3'b010, 32'h10, 32'hDEAD_55EF, 1'b0);
    vecs[11] = ld_v(3'b010, 32'(4 * DEPTH), 32'd0, 1'b1);
    vecs[12] = ld_v(3'b011, 32'h10, 32'd0, 1'b1);
    vecs[13] = st_v(2'b11, 32'h10, 32'h0000_0000, 1'b1);
    vecs[14] = ld_v(3'b010, 32'h10, 32'hDEAD_55EF, 1'b0);
    vecs[15] = st_v(2'b10, 32'h14, 32'h1122_3344, 1'b0);
    vecs[16] = st_v(2'b01, 32'h16, 32'hFFFF_8001, 1'b0);
    vecs[17] = ld_v(3'b010, 32'h14, 32'h8001_3344, 1'b0);
    vecs[18] = ld_v(3'b001, 32'h14, 32'h0000_3344, 1'b0);
    vecs[19] = ld_v(3'b000, 32'h17, 32'hFFFF_FF80, 1'b0);
    vecs[20] = ld_v(3'b101, 32'h16, 32'h0000_8001, 1'b0);
    vecs[21] = ld_v(3'b001, 32'h16, 32'hFFFF_8001, 1'b0);
    vecs[22] = ld_v(3'b100, 32'h15, 32'h0000_0033, 1'b0);
    vecs[23] = ld_v(3'b000, 32'h10, 32'hFFFF_FFEF, 1'b0);
    vecs[24] = st_v(2'b10, 32'(4 * DEPTH - 4), 32'hCAFE_F00D, 1'b0);
    vecs[25] = ld_v(3'b010, 32'(4 * DEPTH - 4), 32'hCAFE_F00D, 1'b0);
    vecs[26] = st_v(2'b00, 32'(4 * DEPTH), 32'h0000_0077, 1'b1);
    vecs[27] = ld_v(3'b110, 32'h10, 32'd0, 1'b1);
    vecs[28] = ld_v(3'b111, 32'h10, 32'd0, 1'b1);
    vecs[29] = st_v(2'b10, 32'h11, 32'h0BAD_0BAD, 1'b1);
    vecs[30] = ld_v(3'b101, 32'h13, 32'd0, 1'b1);
    vecs[31] = ld_v(3'b010, 32'h10, 32'hDEAD_55EF, 1'b0);
    vecs[32] = st_v(2'b10, 32'h20, 32'h0BAD_F00D, 1'b0);
    vecs[33] = ld_v(3'b010, 32'h20, 32'h0BAD_F00D, 1'b0);

    bus_if.req_valid      = 1'b0;
    bus_if.req_write      = 1'b0;
    bus_if.req_addr       = 32'd0;
    bus_if.req_wdata      = 32'd0;
    bus_if.req_store_type = 2'd0;
    bus_if.req_load_type  = 3'd0;
    bus_if.rsp_ready      = 1'b1;
    rst = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 0, 32'(bus_if.req_ready), 32'd0);
    check("reset_rsp_valid", 0, 32'(bus_if.rsp_valid), 32'd0);
    check("reset_rsp_rdata", 0, bus_if.rsp_rdata, 32'd0);
    check("reset_rsp_err",   0, 32'(bus_if.rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 0, 32'(bus_if.req_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].st, vecs[i].lt, rd, er, lat, ok);
      check("vec_completed", i, 32'(ok), 32'd1);
      if (ok) begin
        check("vec_rdata",   i, rd, vecs[i].exp_rdata);
        check("vec_err",     i, 32'(er), 32'(vecs[i].exp_err));
        check("vec_latency", i, 32'(lat), 32'(EXP_LAT));
      end
    end

    // Backpressure: response held while a store sits on the request lines.
    @(negedge clk);
    bus_if.rsp_ready      = 1'b0;
    bus_if.req_valid      = 1'b1;
    bus_if.req_write      = 1'b0;
    bus_if.req_addr       = 32'h10;
    bus_if.req_store_type = 2'b11;
    bus_if.req_load_type  = 3'b010;
    n = 0;
    while (!bus_if.req_ready && n < 20) begin @(negedge clk); n++; end
    check("bp_accept", 0, 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus_if.req_write      = 1'b1;
    bus_if.req_store_type = 2'b10;
    bus_if.req_wdata      = 32'h0000_0000;
    n = 0;
    @(negedge clk);
    while (!bus_if.rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("bp_rsp_seen", 0, 32'(bus_if.rsp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", c, 32'(bus_if.rsp_valid), 32'd1);
      check("bp_rsp_rdata", c, bus_if.rsp_rdata, 32'hDEAD_55EF);
      check("bp_rsp_err",   c, 32'(bus_if.rsp_err), 32'd0);
      check("bp_req_ready", c, 32'(bus_if.req_ready), 32'd0);
    end
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 0, 32'(bus_if.rsp_valid), 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 2'b11, 3'b010, rd, er, lat, ok);
    check("bp_no_second_access", 0, ok ? rd : 32'hFFFF_FFFF, 32'hDEAD_55EF);

    // Reset during the ACCESS cycle of a store drops it and its response.
    @(negedge clk);
    bus_if.req_valid      = 1'b1;
    bus_if.req_write      = 1'b1;
    bus_if.req_addr       = 32'h20;
    bus_if.req_wdata      = 32'h1234_5678;
    bus_if.req_store_type = 2'b10;
    n = 0;
    while (!bus_if.req_ready && n < 20) begin @(negedge clk); n++; end
    check("rst_accept", 0, 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    repeat (W_EFF) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rsp_valid", 0, 32'(bus_if.rsp_valid), 32'd0);
    check("rst_mid_req_ready", 0, 32'(bus_if.req_ready), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_response", c, 32'(bus_if.rsp_valid), 32'd0);
    end
    check("rst_back_to_idle", 0, 32'(bus_if.req_ready), 32'd1);
    do_req(1'b0, 32'h20, 32'd0, 2'b11, 3'b010, rd, er, lat, ok);
    check("rst_store_dropped", 0, ok ? rd : 32'hFFFF_FFFF, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv32i pipeline: the slave end of the core's load/store path. It accepts one request at a time over a valid/ready handshake, performs byte-, half- or word-sized access on an internal word-organised SRAM, and returns a response carrying sign- or zero-extended read data plus an error flag. It sits between the core's memory-stage request port and on-chip data storage, with optional programmable wait states to model slow memory.

## Interface
- `DEPTH_WORDS`, default 1024: SRAM depth in 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, default 2: extra wait states per access; 0–15. Used only when `DMEM_WAIT_STATE_EN` is defined.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_store_type` in 2: 00 SB, 01 SH, 10 SW; 11 is illegal and sets an error.
- `req_load_type` in 3: funct3 encoding. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal and set an error.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: load result, extended to 32 bits; 0 for stores and for errors.
- `rsp_err` out 1: misaligned address, out-of-range address, or illegal type.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE
  - `req_ready` = 1.
  - On `req_valid && req_ready`, capture addr, wdata, type and write into request registers.
  - Go to WAIT if the wait counter is enabled and `WAIT_CYCLES` > 0; otherwise go to ACCESS.
- WAIT
  - The counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - Go to ACCESS when the counter reaches 0.
- ACCESS
  - Evaluate the error conditions:
    - Misaligned: half access with addr[0] = 1, or word access with addr[1:0] ≠ 0.
    - Out of range: addr[31:2] ≥ `DEPTH_WORDS`.
    - Illegal type code.
  - No error, store: write the selected byte lanes only. SB uses lane addr[1:0]; SH uses lanes {addr[1],0} and {addr[1],1}; SW uses all four lanes.
  - No error, load: read the word, shift right by 8·addr[1:0], then sign- or zero-extend per `req_load_type`.
  - Error: no SRAM write; `rsp_rdata` = 0.
  - Register the result and go to RESP.
- RESP
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` are held stable until the handshake.
  - On `rsp_ready`, go to IDLE.
  - `rsp_ready` low keeps the FSM in RESP indefinitely; no new request is accepted.
- Only one request is outstanding at a time; `req_ready` = 0 in every state except IDLE.
- SRAM contents are not cleared by reset.

## Timing
- Reset values: `req_ready` = 0 during reset and 1 from the first cycle after `rst` deasserts. `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0. FSM = IDLE; counter = 0.
- Latency: request accepted at edge N → `rsp_valid` high from edge N+2+W, where W is the effective wait count (0 when the feature is compiled out).
- The store commits to the SRAM at the edge that leaves ACCESS. A load issued after the store's response returns the new data.
- Back-to-back throughput: one request per 3+W cycles (IDLE, [WAIT], ACCESS, RESP), with `rsp_ready` held high.
- `req_valid` with `rsp_valid` still high is ignored until the FSM returns to IDLE.
- Reset asserted mid-transaction (WAIT, ACCESS or RESP):
  - FSM goes to IDLE and the response is dropped.
  - A store whose ACCESS edge coincides with reset does not commit.

## Configuration
- Macro: `DMEM_WAIT_STATE_EN`.
- Defined:
  - The WAIT state and 4-bit wait counter are instantiated.
  - Latency is 2+`WAIT_CYCLES` cycles from request acceptance.
- Undefined:
  - No WAIT state or counter; `WAIT_CYCLES` is ignored.
  - Fixed latency of 2 cycles; IDLE → ACCESS directly.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0. Latency is 2 cycles without the macro, and 4 with the macro and `WAIT_CYCLES` = 2.
- After that word, issue LB 0x13, LBU 0x13, LH 0x12, LHU 0x12 → responses 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD respectively.
- SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF; only lane 1 has changed.
- Error cases, each returning `rsp_err` = 1, `rsp_rdata` = 0, with memory unchanged:
  - LW 0x12 (misaligned).
  - SH 0x11 (misaligned).
  - LW at byte address 4·`DEPTH_WORDS` (out of range).
  - `req_load_type` = 011 (illegal code).
- Hold `rsp_ready` = 0 for 5 cycles with `req_valid` = 1 → `rsp_valid` and its data stay stable, `req_ready` stays 0, and no second access occurs.
- Drive `rst` = 0 in the ACCESS cycle of an SW to 0x20 → FSM returns to IDLE, no response is issued, and a subsequent LW 0x20 returns the prior contents.
